// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter (and the future
// receiver). Provides the parity selection enum, the transmitter state enum,
// and elaboration-time helpers for bit timing and frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  // ST_ prefix keeps the state literals clear of the PARITY parameter name.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per line bit (integer division, remainder dropped).
  function automatic int ticks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Line bits in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int width, input parity_t parity,
                                    input int stop_bits);
    return 1 + width + ((parity == PARITY_NONE) ? 0 : 1) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue read data (rdata always shows the
// oldest entry). Written to be shared with the receive-side buffer.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   push, wdata  : write request and data
//   pop          : remove the head entry
//   rdata        : head entry (valid when !empty)
//   full, empty  : occupancy flags decoded from the level register
//   level        : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  // A push into a full FIFO is allowed only when the head leaves on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: host words enter a FIFO through a valid/ready
// handshake and are sent LSB first as start / data / optional parity / stop
// frames, each line bit held TICKS = CLOCK_FREQ / BAUD_RATE cycles.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   data, valid  : word offered by the host; taken on an edge with valid && ready
//   ready        : FIFO not full
//   signal       : serial TX line, idle high
//   busy         : a frame is in progress
//   level        : FIFO occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int      WIDTH      = 8,
  parameter int      CLOCK_FREQ = 460800,
  parameter int      BAUD_RATE  = 9600,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            data,
  input  logic                        valid,
  output logic                        ready,
  output logic                        signal,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int             TICKS     = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int             TW        = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(WIDTH - 1);
  localparam logic           STOP_LAST = (STOP_BITS == 2);

  if (TICKS < 2) begin : g_bad_ticks
    $error("uart_tx_buffered: CLOCK_FREQ / BAUD_RATE must be at least 2");
  end
  if (WIDTH < 5 || WIDTH > 9) begin : g_bad_width
    $error("uart_tx_buffered: WIDTH must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end

  tx_state_t        state;
  tx_state_t        state_n;
  logic             pop;
  logic             tick_end;
  logic [TW-1:0]    tick;
  logic [3:0]       bit_idx;
  logic             stop_idx;
  logic [WIDTH-1:0] shift;
  logic             par_bit;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (valid && ready),
    .pop   (pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign ready    = !fifo_full;
  assign busy     = (state != ST_IDLE);
  assign tick_end = (tick == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick_end) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (tick_end && bit_idx == BIT_LAST)
          state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (tick_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        // Chain straight into the next start bit when a word is waiting.
        if (tick_end && stop_idx == STOP_LAST) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line value is decoded from flops only, so reset forces it high at once.
  always_comb begin
    signal = 1'b1;
    case (state)
      ST_START:  signal = 1'b0;
      ST_DATA:   signal = shift[0];
      ST_PARITY: signal = par_bit;
      default:   signal = 1'b1;
    endcase
  end

  // Frame datapath: word and parity are captured at pop, so later pushes or
  // changes on data cannot disturb the frame being sent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift    <= '0;
      par_bit  <= 1'b0;
      tick     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (pop) begin
      shift    <= fifo_rdata;
      par_bit  <= (PARITY == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      tick     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (state != ST_IDLE) begin
      if (tick_end) begin
        tick <= '0;
        if (state == ST_DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
        if (state == ST_STOP) stop_idx <= stop_idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule
